ysyx_22041071_axi_rd_arbiter: RTL

- Shares the core's single AXI4 read channel (AR/R) between two requesters: port 0 = instruction fetch, port 1 = load unit (MEM).
- Sequences each transaction and returns the data to the requester that issued it, tagged with the request address.
- Fetch consumes this as cpu_r_valid / cpu_r_data / cpu_r_addr / cpu_resp.
- Sits between the pipeline front/back ends and the top-level AXI master interface.

---
 rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv | 30 +++
 rtl/ysyx_22041071_axi_rd_arbiter_if.sv | 63 ++++++
 rtl/ysyx_22041071_rr_arb2.sv | 32 +++
 rtl/ysyx_22041071_axi_rd_arbiter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/ysyx_22041071_axi_rd_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arbiter_pkg
// Shared widths, FSM encoding, AXI IDs and AXI field constants.
// Rev 1.0
// ---------------------------------------------------------------------------
package ysyx_22041071_axi_rd_arbiter_pkg;

   localparam int ADDR_BUS   = 64;
   localparam int DATA_WIDTH = 64;
   localparam int ID_WIDTH   = 4;
   localparam int RESP_WIDTH = 2;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_RESP = 2'd3
   } arb_state_t;

   localparam logic [3:0] ID_IF  = 4'd0;
   localparam logic [3:0] ID_MEM = 4'd1;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam logic [2:0] SIZE_8B    = 3'b011;
   localparam logic [7:0] LEN_SINGLE = 8'd0;

endpackage
`default_nettype wire

// File: rtl/ysyx_22041071_axi_rd_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arbiter_if
// Requester ports (IF/MEM) plus the shared AXI AR/R channel.
// Rev 1.0
// ---------------------------------------------------------------------------
interface ysyx_22041071_axi_rd_arbiter_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64,
   parameter int ID_W   = 4,
   parameter int RESP_W = 2
);
   logic              if_req_valid;
   logic [ADDR_W-1:0] if_req_addr;
   logic              if_req_ready;
   logic              if_flush;
   logic              if_r_valid;
   logic [DATA_W-1:0] if_r_data;
   logic [ADDR_W-1:0] if_r_addr;
   logic [RESP_W-1:0] if_r_resp;

   logic              mem_req_valid;
   logic [ADDR_W-1:0] mem_req_addr;
   logic [2:0]        mem_req_size;
   logic              mem_req_ready;
   logic              mem_r_valid;
   logic [DATA_W-1:0] mem_r_data;
   logic [RESP_W-1:0] mem_r_resp;

   logic              arvalid;
   logic              arready;
   logic [ADDR_W-1:0] araddr;
   logic [ID_W-1:0]   arid;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;

   logic              rvalid;
   logic              rready;
   logic [DATA_W-1:0] rdata;
   logic [ID_W-1:0]   rid;
   logic [RESP_W-1:0] rresp;
   logic              rlast;

   modport master (
      input  if_req_valid, if_req_addr, if_flush,
      input  mem_req_valid, mem_req_addr, mem_req_size,
      input  arready, rvalid, rdata, rid, rresp, rlast,
      output if_req_ready, if_r_valid, if_r_data, if_r_addr, if_r_resp,
      output mem_req_ready, mem_r_valid, mem_r_data, mem_r_resp,
      output arvalid, araddr, arid, arlen, arsize, arburst, rready
   );

   modport slave (
      output if_req_valid, if_req_addr, if_flush,
      output mem_req_valid, mem_req_addr, mem_req_size,
      output arready, rvalid, rdata, rid, rresp, rlast,
      input  if_req_ready, if_r_valid, if_r_data, if_r_addr, if_r_resp,
      input  mem_req_ready, mem_r_valid, mem_r_data, mem_r_resp,
      input  arvalid, araddr, arid, arlen, arsize, arburst, rready
   );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041071_rr_arb2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22041071_rr_arb2
// Two-way round-robin grant; last_grant only moves when update is set.
// Rev 1.0
// ---------------------------------------------------------------------------
module ysyx_22041071_rr_arb2 (
   input  wire logic       clk,
   input  wire logic       reset,
   input  wire logic [1:0] req,
   input  wire logic       update,
   output logic      [1:0] grant
);
   // 0: port 0 won the last grant, 1: port 1 did
   logic last_grant;

   always_comb begin
      grant = req;
      if (req == 2'b11) begin
         grant = last_grant ? 2'b01 : 2'b10;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         last_grant <= 1'b0;
      end else if (update && (grant != 2'b00)) begin
         last_grant <= grant[1];
      end
   end
endmodule
`default_nettype wire

// File: rtl/ysyx_22041071_axi_rd_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_22041071_axi_rd_arbiter
// Shares one single-beat AXI read channel between fetch (port 0) and load (port 1).
// Rev 1.0
// ---------------------------------------------------------------------------
module ysyx_22041071_axi_rd_arbiter
   import ysyx_22041071_axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_W = ADDR_BUS,
   parameter int DATA_W = DATA_WIDTH,
   parameter int ID_W   = ID_WIDTH,
   parameter int RESP_W = RESP_WIDTH
) (
   input wire logic clk,
   input wire logic reset,
   ysyx_22041071_axi_rd_arbiter_if.master bus
);
   arb_state_t        state;
   logic              owner_mem;
   logic              drop;
   logic [ADDR_W-1:0] if_addr_q;
   logic              arvalid_q;
   logic              rready_q;
   logic [ADDR_W-1:0] araddr_q;
   logic [ID_W-1:0]   arid_q;
   logic [2:0]        arsize_q;
   logic [DATA_W-1:0] data_q;
   logic [RESP_W-1:0] resp_q;
   logic              if_valid_q;
   logic              mem_valid_q;

   logic       idle_ok;
   logic [1:0] grant;
   logic       unused_rlast;

   assign idle_ok      = (state == ST_IDLE) && !reset;
   assign unused_rlast = bus.rlast;

   ysyx_22041071_rr_arb2 u_rr_arb2 (
      .clk    (clk),
      .reset  (reset),
      .req    ({bus.mem_req_valid, bus.if_req_valid}),
      .update (idle_ok),
      .grant  (grant)
   );

   assign bus.if_req_ready  = idle_ok && grant[0];
   assign bus.mem_req_ready = idle_ok && grant[1];

   assign bus.arvalid = arvalid_q;
   assign bus.araddr  = araddr_q;
   assign bus.arid    = arid_q;
   assign bus.arsize  = arsize_q;
   assign bus.arlen   = LEN_SINGLE;
   assign bus.arburst = BURST_INCR;
   assign bus.rready  = rready_q;

   // A flush landing in the RESP cycle itself must still kill the pulse
   assign bus.if_r_valid  = if_valid_q && !bus.if_flush;
   assign bus.if_r_data   = data_q;
   assign bus.if_r_addr   = if_addr_q;
   assign bus.if_r_resp   = resp_q;
   assign bus.mem_r_valid = mem_valid_q;
   assign bus.mem_r_data  = data_q;
   assign bus.mem_r_resp  = resp_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         owner_mem   <= 1'b0;
         drop        <= 1'b0;
         if_addr_q   <= '0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         araddr_q    <= '0;
         arid_q      <= '0;
         arsize_q    <= '0;
         data_q      <= '0;
         resp_q      <= '0;
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
      end else begin
         if_valid_q  <= 1'b0;
         mem_valid_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               drop <= 1'b0;
               if (grant != 2'b00) begin
                  owner_mem <= grant[1];
                  arvalid_q <= 1'b1;
                  state     <= ST_ADDR;
                  if (grant[1]) begin
                     araddr_q <= bus.mem_req_addr;
                     arid_q   <= ID_W'(ID_MEM);
                     arsize_q <= bus.mem_req_size;
                  end else begin
                     // Fetch always reads the whole aligned doubleword
                     araddr_q  <= {bus.if_req_addr[ADDR_W-1:3], 3'b000};
                     arid_q    <= ID_W'(ID_IF);
                     arsize_q  <= SIZE_8B;
                     if_addr_q <= bus.if_req_addr;
                  end
               end
            end
            ST_ADDR: begin
               if (bus.if_flush && !owner_mem) begin
                  drop <= 1'b1;
               end
               if (bus.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state     <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (bus.if_flush && !owner_mem) begin
                  drop <= 1'b1;
               end
               // Beats carrying a foreign ID are consumed silently
               if (bus.rvalid && (bus.rid == arid_q)) begin
                  rready_q <= 1'b0;
                  data_q   <= bus.rdata;
                  resp_q   <= bus.rresp;
                  state    <= ST_RESP;
                  if (owner_mem) begin
                     mem_valid_q <= 1'b1;
                  end else begin
                     if_valid_q <= !(drop || bus.if_flush);
                  end
               end
            end
            ST_RESP: begin
               drop  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end
endmodule
`default_nettype wire
